// File: rtl/ps2_mouse_button_decoder.sv
// Receive-only PS/2 mouse front end: filters ps2_clk, deserialises frames,
// assembles 3-byte stream packets and emits button press pulses.
module ps2_mouse_button_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int BIT_TIMEOUT = 130000,
  parameter int PKT_TIMEOUT = 650000
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic mouse_left,
  output logic mouse_right,
  output logic left_held,
  output logic right_held,
  output logic packet_valid,
  output logic frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int BW = $clog2(BIT_TIMEOUT + 1);
  localparam int PW = $clog2(PKT_TIMEOUT + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [1:0] PK_B0 = 2'd0;
  localparam logic [1:0] PK_B1 = 2'd1;
  localparam logic [1:0] PK_B2 = 2'd2;

  logic [1:0]    r_clk_s;
  logic [1:0]    r_dat_s;
  logic          r_fclk;
  logic          r_fclk_d;
  logic [FW-1:0] r_fcnt;

  logic [0:0]    r_bst;
  logic [3:0]    r_bitcnt;
  logic          r_start;
  logic [7:0]    r_byte;
  logic          r_par;
  logic [BW-1:0] r_btmo;
  logic          r_byte_valid;
  logic [7:0]    r_byte_out;
  logic          r_frame_err;

  logic [1:0]    r_pst;
  logic [PW-1:0] r_ptmo;
  logic          r_lat_l;
  logic          r_lat_r;
  logic          r_ml;
  logic          r_mr;
  logic          r_lh;
  logic          r_rh;
  logic          r_pv;

  logic w_strobe;
  logic w_din;
  logic w_good;

  assign w_strobe = r_fclk_d & ~r_fclk;
  assign w_din    = r_dat_s[1];
  assign w_good   = ~r_start & w_din & (^{r_byte, r_par});

  // Filtered clock moves only after FILTER_LEN agreeing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s  <= 2'b11;
      r_dat_s  <= 2'b11;
      r_fclk   <= 1'b1;
      r_fclk_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_clk_s  <= {r_clk_s[0], ps2_clk};
      r_dat_s  <= {r_dat_s[0], ps2_data};
      r_fclk_d <= r_fclk;
      if (r_clk_s[1] != r_fclk) begin
        if (r_fcnt == FW'(FILTER_LEN - 1)) begin
          r_fclk <= ~r_fclk;
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
      end else begin
        r_fcnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bst        <= ST_IDLE;
      r_bitcnt     <= '0;
      r_start      <= 1'b0;
      r_byte       <= '0;
      r_par        <= 1'b0;
      r_btmo       <= '0;
      r_byte_valid <= 1'b0;
      r_byte_out   <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (r_bst == ST_IDLE) begin
        r_btmo <= '0;
        if (w_strobe) begin
          r_start  <= w_din;
          r_bitcnt <= 4'd1;
          r_bst    <= ST_SHIFT;
        end
      end else if (w_strobe) begin
        r_btmo   <= '0;
        r_bitcnt <= r_bitcnt + 1'b1;
        if (r_bitcnt <= 4'd8) begin
          r_byte <= {w_din, r_byte[7:1]};
        end else if (r_bitcnt == 4'd9) begin
          r_par <= w_din;
        end else begin
          r_bst        <= ST_IDLE;
          r_byte_valid <= w_good;
          r_frame_err  <= ~w_good;
          r_byte_out   <= r_byte;
        end
      end else if (r_btmo == BW'(BIT_TIMEOUT - 1)) begin
        r_bst       <= ST_IDLE;
        r_btmo      <= '0;
        r_frame_err <= 1'b1;
      end else begin
        r_btmo <= r_btmo + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pst   <= PK_B0;
      r_ptmo  <= '0;
      r_lat_l <= 1'b0;
      r_lat_r <= 1'b0;
      r_ml    <= 1'b0;
      r_mr    <= 1'b0;
      r_lh    <= 1'b0;
      r_rh    <= 1'b0;
      r_pv    <= 1'b0;
    end else begin
      r_ml <= 1'b0;
      r_mr <= 1'b0;
      r_pv <= 1'b0;
      if (r_byte_valid) begin
        r_ptmo <= '0;
        unique case (r_pst)
          PK_B0: begin
            if (r_byte_out[3]) begin
              r_lat_l <= r_byte_out[0];
              r_lat_r <= r_byte_out[1];
              r_pst   <= PK_B1;
            end
          end
          PK_B1: r_pst <= PK_B2;
          PK_B2: begin
            r_pst <= PK_B0;
            r_pv  <= 1'b1;
            r_lh  <= r_lat_l;
            r_rh  <= r_lat_r;
            r_ml  <= r_lat_l & ~r_lh;
            r_mr  <= r_lat_r & ~r_rh;
          end
          default: r_pst <= PK_B0;
        endcase
      end else if (r_pst == PK_B0) begin
        r_ptmo <= '0;
      end else if (r_frame_err || r_ptmo == PW'(PKT_TIMEOUT - 1)) begin
        r_pst  <= PK_B0;
        r_ptmo <= '0;
      end else begin
        r_ptmo <= r_ptmo + 1'b1;
      end
    end
  end

  assign mouse_left   = r_ml;
  assign mouse_right  = r_mr;
  assign left_held    = r_lh;
  assign right_held   = r_rh;
  assign packet_valid = r_pv;
  assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_ps2_mouse_button_decoder.sv
// Directed bench for ps2_mouse_button_decoder with shortened timeouts
// and a fast PS/2 clock.
module tb_ps2_mouse_button_decoder;

  localparam int FL   = 8;
  localparam int BTO  = 300;
  localparam int PTO  = 2000;
  localparam int HALF = 30;
  localparam int GAP  = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic mouse_left, mouse_right, left_held, right_held;
  logic packet_valid, frame_err;

  int total = 0;
  int bad = 0;
  int n_pv = 0, n_ml = 0, n_mr = 0, n_fe = 0, n_lone = 0;
  int s_pv, s_ml, s_mr, s_fe;

  ps2_mouse_button_decoder #(
    .FILTER_LEN (FL),
    .BIT_TIMEOUT(BTO),
    .PKT_TIMEOUT(PTO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .mouse_left  (mouse_left),
    .mouse_right (mouse_right),
    .left_held   (left_held),
    .right_held  (right_held),
    .packet_valid(packet_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (packet_valid) n_pv++;
      if (mouse_left) n_ml++;
      if (mouse_right) n_mr++;
      if (frame_err) n_fe++;
      if ((mouse_left | mouse_right) & ~packet_valid) n_lone++;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    s_pv = n_pv;
    s_ml = n_ml;
    s_mr = n_mr;
    s_fe = n_fe;
  endtask

  task automatic send_frame(input logic [7:0] b, input int nbits,
                            input bit badpar, input int gbit);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ badpar, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      if (i == gbit) begin
        cyc(14);
        ps2_clk = 1'b0;
        cyc(FL - 2);
        ps2_clk = 1'b1;
        cyc(HALF - 14 - (FL - 2));
      end else begin
        cyc(HALF);
      end
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cyc(GAP);
  endtask

  task automatic send_pkt(input logic [7:0] b0);
    send_frame(b0, 11, 1'b0, -1);
    send_frame(8'h00, 11, 1'b0, -1);
    send_frame(8'h00, 11, 1'b0, -1);
    cyc(GAP);
  endtask

  task automatic chk_pkt(input string tag, input int pv, input int ml,
                         input int mr, input int fe, input int lh, input int rh);
    chk({tag, ".pv"}, n_pv - s_pv, pv);
    chk({tag, ".ml"}, n_ml - s_ml, ml);
    chk({tag, ".mr"}, n_mr - s_mr, mr);
    chk({tag, ".fe"}, n_fe - s_fe, fe);
    chk({tag, ".lh"}, int'(left_held), lh);
    chk({tag, ".rh"}, int'(right_held), rh);
  endtask

  initial begin
    cyc(5);
    chk("reset.outs", int'({mouse_left, mouse_right, left_held, right_held,
                            packet_valid, frame_err}), 0);
    rst = 1'b0;
    cyc(20);

    snap();
    send_pkt(8'h09);
    chk_pkt("left", 1, 1, 0, 0, 1, 0);

    snap();
    send_pkt(8'h0B);
    chk_pkt("right", 1, 0, 1, 0, 1, 1);

    snap();
    send_pkt(8'h08);
    chk_pkt("release", 1, 0, 0, 0, 0, 0);

    snap();
    send_frame(8'h0A, 11, 1'b0, -1);
    send_frame(8'h00, 11, 1'b1, -1);
    send_pkt(8'h0A);
    chk_pkt("parity", 1, 0, 1, 1, 0, 1);
    send_pkt(8'h08);

    snap();
    send_frame(8'h00, 11, 1'b0, -1);
    send_pkt(8'h0A);
    chk_pkt("resync", 1, 0, 1, 0, 0, 1);
    send_pkt(8'h08);

    snap();
    send_frame(8'h09, 11, 1'b0, -1);
    send_frame(8'h00, 11, 1'b0, -1);
    cyc(PTO + 10);
    send_pkt(8'h0A);
    chk_pkt("pkt_tmo", 1, 0, 1, 0, 0, 1);
    send_pkt(8'h08);

    snap();
    send_frame(8'h09, 11, 1'b0, 4);
    send_frame(8'h00, 11, 1'b0, 2);
    send_frame(8'h00, 11, 1'b0, -1);
    cyc(GAP);
    chk_pkt("glitch", 1, 1, 0, 0, 1, 0);
    send_pkt(8'h08);

    snap();
    send_frame(8'h09, 5, 1'b0, -1);
    cyc(BTO + 10);
    chk("bit_tmo.fe", n_fe - s_fe, 1);
    chk("bit_tmo.pv", n_pv - s_pv, 0);
    snap();
    send_pkt(8'h0A);
    chk_pkt("after_tmo", 1, 0, 1, 0, 0, 1);

    send_pkt(8'h09);
    chk("pre_rst.lh", int'(left_held), 1);
    send_frame(8'h09, 5, 1'b0, -1);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst.outs", int'({mouse_left, mouse_right, left_held, right_held,
                              packet_valid, frame_err}), 0);
    rst = 1'b0;
    cyc(BTO);
    snap();
    send_pkt(8'h09);
    chk_pkt("post_rst", 1, 1, 0, 0, 1, 0);

    chk("lone_pulse", n_lone, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
